// File: rtl/branch_predictor_pht.sv
// Pattern history table of saturating counters, bimodal or gshare indexed.
// Predictions register one cycle after lookup; the table is filled by a post-reset sweep.
module branch_predictor_pht #(
  parameter int unsigned INDEX_BITS = 8,
  parameter int unsigned CTR_BITS   = 2,
  parameter int unsigned INIT_CTR   = 3,
  parameter int unsigned HIST_BITS  = 8,
  parameter int unsigned MODE       = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  lookup_valid,
  input  logic [31:0]           inst,
  input  logic [31:0]           branch_pc,
  input  logic [31:0]           taken_pc,
  input  logic [31:0]           not_taken_pc,
  input  logic                  update_valid,
  input  logic [INDEX_BITS-1:0] update_index,
  input  logic                  update_taken,
  output logic                  pred_valid,
  output logic                  pred_taken,
  output logic [31:0]           predicted_pc,
  output logic [INDEX_BITS-1:0] pred_index,
  output logic                  init_busy
);

  localparam int unsigned ENTRIES = 2 ** INDEX_BITS;
  localparam logic [CTR_BITS-1:0] InitVal = CTR_BITS'(INIT_CTR);
  localparam logic [CTR_BITS-1:0] CtrMax  = '1;

  typedef enum logic [0:0] {StInit, StRun} state_e;

  state_e                state_q, state_d;
  logic [INDEX_BITS-1:0] sweep_q, sweep_d;
  logic [HIST_BITS-1:0]  ghr_q, ghr_d, ghr_shift;
  logic [CTR_BITS-1:0]   pht [ENTRIES];

  logic                  is_branch;
  logic                  do_update;
  logic [INDEX_BITS-1:0] hist_ext;
  logic [INDEX_BITS-1:0] lookup_idx;
  logic [CTR_BITS-1:0]   upd_ctr, upd_next, look_ctr;
  logic                  unused_bits;

  assign unused_bits = ^{inst[25:0], branch_pc[31:INDEX_BITS+2], branch_pc[1:0]};

  assign is_branch = inst[31:26] inside {6'd1, 6'd4, 6'd5, 6'd6, 6'd7};
  assign init_busy = (state_q == StInit);
  assign do_update = update_valid && (state_q == StRun);

  // History occupies the low index bits; bimodal ignores it.
  assign hist_ext   = (MODE != 0) ? INDEX_BITS'(ghr_q) : '0;
  assign lookup_idx = branch_pc[INDEX_BITS+1:2] ^ hist_ext;

  generate
    if (HIST_BITS == 1) begin : g_hist1
      assign ghr_shift = update_taken;
    end else begin : g_histn
      assign ghr_shift = {ghr_q[HIST_BITS-2:0], update_taken};
    end
  endgenerate

  always_comb begin
    upd_ctr  = pht[update_index];
    upd_next = upd_ctr;
    if (update_taken) begin
      if (upd_ctr != CtrMax) upd_next = upd_ctr + 1'b1;
    end else begin
      if (upd_ctr != '0) upd_next = upd_ctr - 1'b1;
    end
  end

  // Same-cycle update to the looked-up entry is forwarded to the prediction.
  always_comb begin
    look_ctr = pht[lookup_idx];
    if (state_q == StInit) begin
      look_ctr = InitVal;
    end else if (do_update && (update_index == lookup_idx)) begin
      look_ctr = upd_next;
    end
  end

  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    ghr_d   = ghr_q;
    unique case (state_q)
      StInit: begin
        sweep_d = sweep_q + 1'b1;
        if (sweep_q == {INDEX_BITS{1'b1}}) state_d = StRun;
      end
      StRun: begin
        if (update_valid) ghr_d = ghr_shift;
      end
      default: state_d = StInit;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StInit;
      sweep_q <= '0;
      ghr_q   <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
      ghr_q   <= ghr_d;
    end
  end

  // Table storage has no reset; the sweep is what initialises it.
  always_ff @(posedge clk) begin
    if (state_q == StInit) begin
      pht[sweep_q] <= InitVal;
    end else if (do_update) begin
      pht[update_index] <= upd_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pred_valid   <= 1'b0;
      pred_taken   <= 1'b0;
      predicted_pc <= '0;
      pred_index   <= '0;
    end else if (lookup_valid && is_branch) begin
      pred_valid   <= 1'b1;
      pred_taken   <= look_ctr[CTR_BITS-1];
      predicted_pc <= look_ctr[CTR_BITS-1] ? taken_pc : not_taken_pc;
      pred_index   <= lookup_idx;
    end else begin
      pred_valid   <= 1'b0;
    end
  end

endmodule
